// File: rtl/dual_issue_pkg.sv
// Shared decode constants, FSM state type and source-use helpers for the
// dual-issue decode stage.
package dual_issue_pkg;

  localparam int REG_W = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPLIT = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_STORE, OP_RTYPE, OP_BRANCH};
  endfunction

endpackage

// File: rtl/dual_issue_hazard_if.sv
// Decode/EX-side inputs and issue-control outputs of the hazard unit.
interface dual_issue_hazard_if
  import dual_issue_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [6:0]       id_opcode1, id_opcode2;
  logic [REG_W-1:0] id_rs1_1, id_rs2_1, id_rs1_2, id_rs2_2;
  logic [REG_W-1:0] id_rd1;
  logic             id_regwrite1;
  logic             ex_memread1, ex_memread2;
  logic [REG_W-1:0] ex_rd1, ex_rd2;
  logic             ex_branch_taken;

  logic             stall;
  logic             pc_write;
  logic             ifid_write;
  logic             kill1, kill2;
  logic             flush;
  logic             busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_opcode1, id_opcode2, id_rs1_1, id_rs2_1, id_rs1_2, id_rs2_2,
           id_rd1, id_regwrite1, ex_memread1, ex_memread2, ex_rd1, ex_rd2, ex_branch_taken,
    input  stall, pc_write, ifid_write, kill1, kill2, flush, busy, stall_count
  );

  modport slave (
    input  id_valid, id_opcode1, id_opcode2, id_rs1_1, id_rs2_1, id_rs1_2, id_rs2_2,
           id_rd1, id_regwrite1, ex_memread1, ex_memread2, ex_rd1, ex_rd2, ex_branch_taken,
    output stall, pc_write, ifid_write, kill1, kill2, flush, busy, stall_count
  );
endinterface

// File: rtl/hazard_src_match.sv
// Flags when a slot actually reads a given (non-x0) destination register.
module hazard_src_match
  import dual_issue_pkg::*;
(
  input  logic [6:0]       i_opcode,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic [REG_W-1:0] i_cmp_rd,
  input  logic             i_cmp_en,
  output logic             o_match
);
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = uses_rs1(i_opcode) && (i_rs1 == i_cmp_rd);
  assign w_rs2_hit = uses_rs2(i_opcode) && (i_rs2 == i_cmp_rd);
  assign o_match   = i_cmp_en && (i_cmp_rd != '0) && (w_rs1_hit || w_rs2_hit);
endmodule

// File: rtl/dual_issue_hazard_unit.sv
// Load-use / intra-pair RAW / branch-flush issue control for the dual-issue
// decode stage, with a saturating stall-cycle counter.
module dual_issue_hazard_unit
  import dual_issue_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  dual_issue_hazard_if.slave bus
);
  localparam int         NPAIR      = 5;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  // Pair order: s1/ex1, s1/ex2, s2/ex1, s2/ex2, s2/id_rd1
  logic [6:0]       w_opc [NPAIR];
  logic [REG_W-1:0] w_rs1 [NPAIR];
  logic [REG_W-1:0] w_rs2 [NPAIR];
  logic [REG_W-1:0] w_cmp [NPAIR];
  logic             w_en  [NPAIR];
  logic [NPAIR-1:0] w_hit;

  assign w_opc[0] = bus.id_opcode1; assign w_rs1[0] = bus.id_rs1_1; assign w_rs2[0] = bus.id_rs2_1;
  assign w_opc[1] = bus.id_opcode1; assign w_rs1[1] = bus.id_rs1_1; assign w_rs2[1] = bus.id_rs2_1;
  assign w_opc[2] = bus.id_opcode2; assign w_rs1[2] = bus.id_rs1_2; assign w_rs2[2] = bus.id_rs2_2;
  assign w_opc[3] = bus.id_opcode2; assign w_rs1[3] = bus.id_rs1_2; assign w_rs2[3] = bus.id_rs2_2;
  assign w_opc[4] = bus.id_opcode2; assign w_rs1[4] = bus.id_rs1_2; assign w_rs2[4] = bus.id_rs2_2;

  assign w_cmp[0] = bus.ex_rd1; assign w_en[0] = bus.ex_memread1;
  assign w_cmp[1] = bus.ex_rd2; assign w_en[1] = bus.ex_memread2;
  assign w_cmp[2] = bus.ex_rd1; assign w_en[2] = bus.ex_memread1;
  assign w_cmp[3] = bus.ex_rd2; assign w_en[3] = bus.ex_memread2;
  assign w_cmp[4] = bus.id_rd1; assign w_en[4] = bus.id_regwrite1;

  genvar gi;
  generate
    for (gi = 0; gi < NPAIR; gi++) begin : g_match
      hazard_src_match u_match (
        .i_opcode (w_opc[gi]),
        .i_rs1    (w_rs1[gi]),
        .i_rs2    (w_rs2[gi]),
        .i_cmp_rd (w_cmp[gi]),
        .i_cmp_en (w_en[gi]),
        .o_match  (w_hit[gi])
      );
    end
  endgenerate

  logic w_lu_s1, w_lu_s2, w_lu_any, w_ph;
  assign w_lu_s1  = bus.id_valid && (w_hit[0] || w_hit[1]);
  assign w_lu_s2  = bus.id_valid && (w_hit[2] || w_hit[3]);
  assign w_lu_any = w_lu_s1 || w_lu_s2;
  assign w_ph     = bus.id_valid && w_hit[4];

  hz_state_t        r_state, w_state_next;
  logic [2:0]       r_flush_cnt, w_flush_cnt_next;
  logic [CNT_W-1:0] r_stall_count;
  logic             w_stall, w_pc_write, w_ifid_write, w_kill1, w_kill2, w_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_flush_cnt   <= 3'd0;
      r_stall_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      if (w_stall && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    if (bus.ex_branch_taken) begin
      w_flush_cnt_next = FLUSH_LOAD;
      w_state_next     = (FLUSH_LOAD != 3'd0) ? ST_FLUSH : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (!w_lu_any && w_ph) w_state_next = ST_SPLIT;
        ST_SPLIT: if (!w_lu_s2) w_state_next = ST_IDLE;
        ST_FLUSH: begin
          w_flush_cnt_next = r_flush_cnt - 3'd1;
          if (r_flush_cnt <= 3'd1) w_state_next = ST_IDLE;
        end
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_stall      = 1'b0;
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_kill1      = 1'b0;
    w_kill2      = 1'b0;
    w_flush      = 1'b0;
    if (bus.ex_branch_taken || (r_state == ST_FLUSH)) begin
      w_flush = 1'b1;
      w_kill1 = 1'b1;
      w_kill2 = 1'b1;
    end else if (r_state == ST_IDLE) begin
      if (w_lu_any) begin
        {w_stall, w_kill1, w_kill2} = 3'b111;
        {w_pc_write, w_ifid_write}  = 2'b00;
      end else if (w_ph) begin
        w_kill2                    = 1'b1;
        {w_pc_write, w_ifid_write} = 2'b00;
      end
    end else if (r_state == ST_SPLIT) begin
      // Slot 1 already left on the previous cycle; only slot 2 is still here.
      w_kill1 = 1'b1;
      if (w_lu_s2) begin
        {w_stall, w_kill2}         = 2'b11;
        {w_pc_write, w_ifid_write} = 2'b00;
      end
    end
  end

  assign bus.stall       = w_stall;
  assign bus.pc_write    = w_pc_write;
  assign bus.ifid_write  = w_ifid_write;
  assign bus.kill1       = w_kill1;
  assign bus.kill2       = w_kill2;
  assign bus.flush       = w_flush;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.stall_count = r_stall_count;
endmodule
